interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  Edge-latching, maskable, priority interrupt controller between peripheral IRQ lines (timers, UART)
//  and the bexkat1 CPU. Captures rising edges into pending bits, selects the highest-index enabled
//  source, presents it with a req/ack handshake, and tracks one in-service interrupt until EOI.
//  Software sees mask/pending/in-service through a small config register port.
// PARAMETERS
//  NSRC  6  number of interrupt sources (idx 5..0 = TIMER3,TIMER2,TIMER1,TIMER0,UART0_RX,UART0_TX)
//  SRCW  3  width of source index, >= clog2(NSRC)
// PORTS
//  clk_i        in   1     system clock, all logic on rising edge
//  rst_i        in   1     asynchronous, active-low reset
//  irq_i        in   NSRC  interrupt request lines, synchronous to clk_i
//  enabled      in   1     global interrupt enable
//  cfg_we       in   1     config write strobe
//  cfg_addr     in   2     0=MASK 1=PENDING 2=INSERVICE 3=STATUS
//  cfg_wdata    in   NSRC  write data
//  cfg_rdata    out  NSRC  read data (combinational on cfg_addr)
//  int_req_o    out  1     interrupt request to CPU
//  int_src_o    out  SRCW  index of requested source, valid while int_req_o=1
//  int_ack_i    in   1     CPU accepts current request
//  int_eoi_i    in   1     CPU end-of-interrupt for in-service source
// BEHAVIOUR
//  Reset (rst_i=0, async): mask=0, pending=0, inservice=0, irq_q=0, state=IDLE, int_req_o=0,
//   int_src_o=0. Reset mid-handshake drops req immediately; irq_i held high across release is
//   seen as a rising edge on the first clock (irq_q resets to 0).
//  Edge capture: rise = irq_i & ~irq_q; irq_q <= irq_i each clock. pending |= rise, independent of
//   mask/enabled/state. Set beats clear: rise on a bit cleared same cycle (ack or W1C) leaves it 1.
//  Config: addr0 write -> mask<=wdata; addr1 write -> pending &= ~wdata (W1C); addr2/3 writes ignored.
//   Read: 0 mask, 1 pending, 2 inservice, 3 {state[1:0],int_src_o} zero-extended to NSRC.
//  eligible = pending & mask; pick = highest set index of eligible.
//  FSM (2-bit): IDLE=0, REQ=1, SERVICE=2.
//   IDLE: if enabled & |eligible -> REQ, int_src_o<=pick. Latency: irq rise sampled at edge E0 ->
//    pending at E0 -> int_req_o high after E1 (2 edges).
//   REQ: int_req_o=1, int_src_o held stable (no re-prioritisation, higher arrival waits).
//    int_ack_i=1 -> pending[src]<=0, inservice[src]<=1, -> SERVICE (ack wins over withdrawal).
//    else if ~enabled or ~eligible[src] (masked or W1C) -> IDLE, int_req_o drops (withdrawn).
//   SERVICE: int_req_o=0; new edges still latch. int_eoi_i=1 -> inservice<=0 -> IDLE; next request
//    may assert on following edge (1 idle cycle minimum).
//  int_ack_i outside REQ and int_eoi_i outside SERVICE ignored. No nesting: one in-service max.
//  int_req_o, int_src_o registered (state-decoded), no combinational path from irq_i.
// TESTING
//  1 Reset: rst_i=0 with irq_i=6'h3F -> all regs 0, int_req_o=0; release, mask=3F -> req, src=5.
//  2 Priority: mask=3F, pulse irq[1] and irq[4] same cycle -> src=4; ack, eoi -> src=1 next.
//  3 Latency/handshake: irq[2] rises at E0 -> int_req_o=1 after E1; ack at E3 -> pending=0,
//    inservice=6'h04, req low; eoi -> inservice=0, state IDLE.
//  4 Withdraw: in REQ src=3, write mask=0 -> req drops next edge, pending[3] stays 1; mask=3F
//    again -> re-request src=3. Repeat with ack same cycle as mask write -> SERVICE.
//  5 Set-vs-clear: irq[0] rises same cycle as ack of src=0 (re-edge) -> pending[0]=1 after ack;
//    W1C of pending[2] same cycle as its rise -> pending[2]=1.
//  6 Global enable: enabled=0, edges on all 6 lines -> pending=3F, no req; enabled=1 -> src=5;
//    int_eoi_i in IDLE and int_ack_i in SERVICE -> no state change.

Source files
------------

// File: rtl/interrupt_controller.sv
// Edge-latching, maskable, priority interrupt controller for the bexkat1 CPU.
// Rising edges on irq_i latch into pending; the highest-index pending & masked
// source is requested over a req/ack handshake and tracked as in-service
// until the CPU signals end-of-interrupt.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | no request outstanding, waiting for an eligible source
// S_REQ     | int_req_o high, int_src_o frozen until ack or withdrawal
// S_SERVICE | one source in service, waiting for int_eoi_i
module interrupt_controller #(
  parameter int NSRC = 6,
  parameter int SRCW = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NSRC-1:0] irq_i,
  input  logic            enabled,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [NSRC-1:0] cfg_wdata,
  output logic [NSRC-1:0] cfg_rdata,
  output logic            int_req_o,
  output logic [SRCW-1:0] int_src_o,
  input  logic            int_ack_i,
  input  logic            int_eoi_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SRCW-1:0]   r_src;
  logic [SRCW-1:0]   w_src_nxt;
  logic [NSRC-1:0]   r_irq_q;
  logic [NSRC-1:0]   r_mask;
  logic [NSRC-1:0]   r_pending;
  logic [NSRC-1:0]   r_inservice;

  logic [NSRC-1:0]   w_rise;
  logic [NSRC-1:0]   w_eligible;
  logic [NSRC-1:0]   w_src_oh;
  logic [NSRC-1:0]   w_clr;
  logic [SRCW-1:0]   w_pick;
  logic              w_ack;
  logic              w_eoi;
  logic              w_mask_we;
  logic              w_w1c_we;
  logic [SRCW+1:0]   w_status;

  assign w_rise     = irq_i & ~r_irq_q;
  assign w_eligible = r_pending & r_mask;
  assign w_src_oh   = NSRC'(1) << r_src;
  assign w_mask_we  = cfg_we && (cfg_addr == 2'd0);
  assign w_w1c_we   = cfg_we && (cfg_addr == 2'd1);
  // Rising edges are OR-ed in after clearing, so a set always beats a clear.
  assign w_clr      = (w_ack ? w_src_oh : '0) | (w_w1c_we ? cfg_wdata : '0);

  assign int_req_o  = (r_state == S_REQ);
  assign int_src_o  = r_src;

  // Highest-index eligible source; later loop iterations override earlier ones.
  always_comb begin
    w_pick = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_eligible[i]) w_pick = SRCW'(i);
    end
  end

  // Next-state logic; ack in REQ takes precedence over withdrawal.
  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_ack       = 1'b0;
    w_eoi       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enabled && (|w_eligible)) begin
          w_state_nxt = S_REQ;
          w_src_nxt   = w_pick;
        end
      end
      S_REQ: begin
        if (int_ack_i) begin
          w_ack       = 1'b1;
          w_state_nxt = S_SERVICE;
        end else if (!enabled || !(|(w_eligible & w_src_oh))) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (int_eoi_i) begin
          w_eoi       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state and the registered source index.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_src   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_src_nxt;
    end
  end

  // Edge detector, mask, pending and in-service registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_irq_q     <= '0;
      r_mask      <= '0;
      r_pending   <= '0;
      r_inservice <= '0;
    end else begin
      r_irq_q   <= irq_i;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (w_mask_we) r_mask <= cfg_wdata;
      if (w_ack) begin
        r_inservice <= r_inservice | w_src_oh;
      end else if (w_eoi) begin
        r_inservice <= '0;
      end
    end
  end

  assign w_status = {r_state, r_src};

  // Combinational register read-back.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata = r_mask;
      2'd1:    cfg_rdata = r_pending;
      2'd2:    cfg_rdata = r_inservice;
      default: cfg_rdata = NSRC'(w_status);
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: a behavioural model predicts the
// outputs after every clock and a monitor compares them against the DUT.
module tb_interrupt_controller;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] irq_i;
  logic       enabled;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [5:0] cfg_wdata;
  logic [5:0] cfg_rdata;
  logic       int_req_o;
  logic [2:0] int_src_o;
  logic       int_ack_i;
  logic       int_eoi_i;

  interrupt_controller #(.NSRC(6), .SRCW(3)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .irq_i     (irq_i),
    .enabled   (enabled),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .int_req_o (int_req_o),
    .int_src_o (int_src_o),
    .int_ack_i (int_ack_i),
    .int_eoi_i (int_eoi_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       req;
    logic [2:0] src;
    logic [5:0] rdata;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: phase 0 = waiting, 1 = requesting, 2 = in service.
  logic [5:0] m_mask, m_pend, m_insvc, m_irq_q;
  int         m_phase, m_src;

  function automatic int highest(input logic [5:0] v);
    for (int i = 5; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [5:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_mask;
      2'd1:    return m_pend;
      2'd2:    return m_insvc;
      default: return {1'b0, 2'(m_phase), 3'(m_src)};
    endcase
  endfunction

  task automatic model_reset();
    m_mask = '0; m_pend = '0; m_insvc = '0; m_irq_q = '0;
    m_phase = 0; m_src = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one clock: predict the post-edge outputs, queue them, clock.
  task automatic step();
    logic [5:0] rise, clr, elig;
    exp_t e;
    if (!cfg_we) cfg_addr = 2'($urandom_range(0, 3));
    rise = irq_i & ~m_irq_q;
    elig = m_pend & m_mask;
    clr  = '0;
    case (m_phase)
      0: if (enabled && elig != 0) begin m_phase = 1; m_src = highest(elig); end
      1: begin
        if (int_ack_i) begin
          clr[m_src] = 1'b1; m_insvc[m_src] = 1'b1; m_phase = 2;
        end else if (!enabled || !elig[m_src]) begin
          m_phase = 0;
        end
      end
      default: if (int_eoi_i) begin m_insvc = '0; m_phase = 0; end
    endcase
    if (cfg_we && cfg_addr == 2'd1) clr = clr | cfg_wdata;
    m_pend = (m_pend & ~clr) | rise;
    if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata;
    m_irq_q = irq_i;
    e.req   = (m_phase == 1);
    e.src   = 3'(m_src);
    e.rdata = model_read(cfg_addr);
    q.push_back(e);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input logic [5:0] bits);
    irq_i = bits; step(); irq_i = '0; step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [5:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; step(); cfg_we = 1'b0;
  endtask

  task automatic ack_it();
    int_ack_i = 1'b1; step(); int_ack_i = 1'b0;
  endtask

  task automatic eoi_it();
    int_eoi_i = 1'b1; step(); int_eoi_i = 1'b0;
  endtask

  // Monitor: every clock that has a prediction is compared against the DUT.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (int_req_o === e.req && int_src_o === e.src && cfg_rdata === e.rdata)
          n_pass++;
        else
          $display("FAIL outputs @%0t addr=%0d: got req=%b src=%0d rdata=%h expected req=%b src=%0d rdata=%h",
                   $time, cfg_addr, int_req_o, int_src_o, cfg_rdata, e.req, e.src, e.rdata);
      end
    end
  end

  initial begin
    int guard;
    rst_i = 1'b0; irq_i = 6'h3F; enabled = 1'b1; cfg_we = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; int_ack_i = 1'b0; int_eoi_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      #1;
      chk($sformatf("reset_reg%0d", a), int'(cfg_rdata), 0);
    end
    chk("reset_req", int'(int_req_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Reset release with irq held high, then unmask everything.
    wr(2'd0, 6'h3F);
    irq_i = '0;
    idle(2);
    ack_it(); eoi_it();
    // Drain the remaining pending sources in priority order.
    for (int i = 0; i < 5; i++) begin
      idle(1); ack_it(); eoi_it();
    end

    // Priority between simultaneous edges, then the lower one follows.
    pulse(6'b010010);
    idle(1); ack_it(); eoi_it();
    idle(1); ack_it(); eoi_it();

    // Latency and handshake on a single source.
    pulse(6'h04);
    idle(1); ack_it(); idle(1); eoi_it(); idle(1);

    // Withdrawal by masking, re-request, then ack in the same cycle as the mask write.
    pulse(6'h08);
    wr(2'd0, 6'h00); idle(2);
    wr(2'd0, 6'h3F); idle(2);
    int_ack_i = 1'b1; wr(2'd0, 6'h00); int_ack_i = 1'b0;
    idle(1); eoi_it(); wr(2'd0, 6'h3F);

    // Set beats clear: re-edge during ack, and W1C colliding with a rise.
    wr(2'd0, 6'h01);
    pulse(6'h01);
    irq_i = 6'h01; int_ack_i = 1'b1; step(); int_ack_i = 1'b0; irq_i = '0;
    idle(1); eoi_it();
    irq_i = 6'h04; wr(2'd1, 6'h04); irq_i = '0;
    idle(2);
    wr(2'd1, 6'h3F);
    wr(2'd0, 6'h3F);

    // Global enable gating and ignored ack/eoi outside their states.
    enabled = 1'b0;
    idle(2);
    if (m_phase == 2) eoi_it();
    pulse(6'h3F);
    idle(3);
    eoi_it();
    enabled = 1'b1;
    idle(2);
    eoi_it();
    ack_it(); ack_it();
    idle(1);
    eoi_it(); idle(2);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      irq_i     = irq_i ^ 6'($urandom & $urandom & $urandom);
      enabled   = ($urandom_range(0, 15) != 0);
      int_ack_i = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      int_eoi_i = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      cfg_we    = ($urandom_range(0, 11) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_wdata = 6'($urandom | $urandom);
      step();
    end
    cfg_we = 1'b0; int_ack_i = 1'b0; int_eoi_i = 1'b0; enabled = 1'b1;

    // Asynchronous reset while requesting, with irq held high across release.
    wr(2'd0, 6'h3F);
    irq_i = 6'h08;
    guard = 0;
    while (m_phase != 1 && guard < 40) begin
      int_eoi_i = (m_phase == 2);
      step();
      guard++;
    end
    int_eoi_i = 1'b0;
    chk("reach_req_timeout", guard < 40 ? 1 : 0, 1);
    #2 rst_i = 1'b0;
    #1;
    chk("async_reset_req", int'(int_req_o), 0);
    chk("async_reset_src", int'(int_src_o), 0);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    wr(2'd0, 6'h3F);
    idle(2);
    ack_it(); eoi_it(); idle(2);

    #3;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
